branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Arbitrates the single shared branch-target adder between two requesters:
  - the EX-stage conditional branch unit;
  - the ID-stage JAL unit.
- Registers the resulting PC redirect and sequences the pipeline flush/stall window that follows it.
- Sits between the EX/ID control logic and the IF-stage PC mux. The adder itself stays an external instance, driven through this block's operand ports.

Parameters:
- PC_W, 8: PC/address width, matching the 8-bit instruction address space.
- IMM_W, 64: immediate width, from the immediate generator.
- FLUSH_CYC, 2: cycles flush_if stays asserted after a redirect. Legal range 1..15.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_req  in  1  EX branch request (branch instruction valid in EX).
- ex_pc  in  PC_W  PC of the EX branch.
- ex_imm  in  IMM_W  branch immediate, not yet shifted.
- ex_taken  in  1  resolved condition (rs1==rs2 for beq).
- ex_gnt  out  1  EX request accepted this cycle (combinational).
- id_req  in  1  ID JAL request.
- id_pc  in  PC_W  PC of the JAL.
- id_imm  in  IMM_W  JAL immediate, not yet shifted.
- id_gnt  out  1  ID request accepted this cycle (combinational).
- add_pc  out  PC_W  operand to the shared adder.
- add_imm  out  IMM_W  operand to the shared adder.
- add_target  in  PC_W  adder result: (add_pc + (add_imm<<1)) mod 2^PC_W.
- redirect_valid  out  1  one-cycle pulse; the PC mux loads redirect_pc.
- redirect_pc  out  PC_W  registered target.
- flush_if  out  1  squash the IF/ID register.
- flush_id  out  1  squash the ID/EX register.
- busy  out  1  high while in FLUSH; ID must stall.

Behaviour:
- Reset: the asynchronous assertion of rst_n forces:
  - state=IDLE, cnt=0;
  - redirect_valid=0, redirect_pc=0;
  - flush_if=0, flush_id=0, busy=0.
  - Reset mid-FLUSH aborts the window immediately; no redirect is reissued.
- FSM states are IDLE and FLUSH.
- IDLE arbitration is fixed priority, EX over ID (EX holds the older instruction):
  - ex_req=1: ex_gnt=1, id_gnt=0, add_pc=ex_pc, add_imm=ex_imm.
  - else id_req=1: id_gnt=1, add_pc=id_pc, add_imm=id_imm.
  - else add_pc=0, add_imm=0, no grant.
- Taken event = (ex_gnt & ex_taken) | id_gnt.
  - On the clock edge that ends the grant cycle N: redirect_pc <= add_target, state <= FLUSH, cnt <= FLUSH_CYC-1.
  - Cycle N+1: redirect_valid=1 (exactly one cycle), flush_if=1, busy=1.
    - flush_id=1 only for an EX-sourced redirect (wrong-path instruction in ID).
    - A JAL redirect leaves ID/EX intact, since the JAL itself proceeds.
- Not-taken EX branch: ex_gnt pulses, no redirect, state remains IDLE. A simultaneous id_req is not granted that cycle.
- EX-taken with simultaneous id_req: the ID request is dropped (wrong path) and is never granted later unless re-presented after the flush.
- FLUSH state:
  - ex_gnt=id_gnt=0 regardless of requests; flush_if=1, busy=1.
  - flush_id is high only in the first FLUSH cycle.
  - cnt decrements each cycle; when cnt==0, next state is IDLE.
  - Total flush_if width = FLUSH_CYC cycles.
- Width rules:
  - Only the low PC_W bits of the target are used; wrap modulo 2^PC_W is legal (no exception).
  - The immediate is signed; the shift and add are performed externally and are not re-checked here.
- redirect_pc holds its value until the next redirect.

Optional Feature:
- BRANCH_STATS_EN defined: adds three 16-bit saturating counters, each with a read-only output port:
  - stat_taken: EX taken;
  - stat_not_taken: EX not-taken;
  - stat_jal: ID grants.
  - Counters are cleared by rst_n and increment on the grant edge.
- Undefined: the counters and ports are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, FLUSH};
  - PC_W/IMM_W defaults;
  - a redirect-source enum {SRC_EX, SRC_ID}.
- One natural sub-module: flush_timer. It is a loadable down-counter with a done flag, reusable for other squash windows.

Test Plan:
- ex_req=1, ex_taken=1, ex_pc=8'h10, ex_imm=4 (adder returns 8'h18) -> ex_gnt in cycle N; cycle N+1 redirect_valid=1, redirect_pc=8'h18, flush_if=1 and flush_id=1; flush_if held 2 cycles, then IDLE.
- ex_req=1, ex_taken=0 -> ex_gnt=1, no redirect_valid, flush_if=0, busy=0.
- ex_req=1 taken (pc 8'h20, imm -2 -> 8'h1C) together with id_req=1 -> only ex_gnt; redirect_pc=8'h1C; id_gnt never asserts during FLUSH.
- id_req=1, id_pc=8'hFC, id_imm=2 -> redirect_pc=8'h00 (wrap); flush_if=1, flush_id=0.
- Redirect issued, then rst_n low during the second FLUSH cycle -> all outputs 0 immediately; after release, the next ex_req is granted in the first cycle.
- BRANCH_STATS_EN: 3 taken, 2 not-taken, 1 JAL -> stat_taken=3, stat_not_taken=2, stat_jal=1.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the branch redirect controller: FSM states, redirect source,
// default widths and the saturating-counter helper used by the optional statistics.
package branch_redirect_ctrl_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int IMM_W_DEF = 64;
  localparam int CNT_W     = 4;
  localparam int STAT_W    = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef enum logic {
    SRC_EX = 1'b0,
    SRC_ID = 1'b1
  } src_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_flush_timer.sv
// Loadable down-counter with a done flag; times squash windows after a redirect.
module branch_redirect_ctrl_flush_timer
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_r;

  assign done = (cnt_r == '0);

  // Count register: load wins over decrement, holds at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && !done) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Arbitrates the shared branch-target adder (EX branch over ID JAL), registers the
// redirect and sequences the flush window. Optional counters: BRANCH_STATS_EN.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int IMM_W     = IMM_W_DEF,
  parameter int FLUSH_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_req,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [IMM_W-1:0] ex_imm,
  input  logic             ex_taken,
  output logic             ex_gnt,
  input  logic             id_req,
  input  logic [PC_W-1:0]  id_pc,
  input  logic [IMM_W-1:0] id_imm,
  output logic             id_gnt,
  output logic [PC_W-1:0]  add_pc,
  output logic [IMM_W-1:0] add_imm,
  input  logic [PC_W-1:0]  add_target,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken,
  output logic [STAT_W-1:0] stat_jal
`endif
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);

  state_e           state_r, state_nxt_s;
  src_e             src_s;
  logic             taken_s;
  logic             ex_gnt_s, id_gnt_s;
  logic [PC_W-1:0]  add_pc_s;
  logic [IMM_W-1:0] add_imm_s;
  logic             timer_load_s, timer_dec_s, timer_done_s;

  logic             redirect_valid_r, redirect_valid_nxt_s;
  logic [PC_W-1:0]  redirect_pc_r, redirect_pc_nxt_s;
  logic             flush_if_r, flush_if_nxt_s;
  logic             flush_id_r, flush_id_nxt_s;
  logic             busy_r, busy_nxt_s;

  // Adder arbitration: only IDLE grants, EX holds the older instruction.
  always_comb begin
    ex_gnt_s  = 1'b0;
    id_gnt_s  = 1'b0;
    add_pc_s  = '0;
    add_imm_s = '0;
    src_s     = SRC_EX;
    taken_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ex_req) begin
          ex_gnt_s  = 1'b1;
          add_pc_s  = ex_pc;
          add_imm_s = ex_imm;
          taken_s   = ex_taken;
        end else if (id_req) begin
          id_gnt_s  = 1'b1;
          add_pc_s  = id_pc;
          add_imm_s = id_imm;
          src_s     = SRC_ID;
          taken_s   = 1'b1;
        end else begin
          taken_s   = 1'b0;
        end
      end
      FLUSH:   taken_s = 1'b0;
      default: taken_s = 1'b0;
    endcase
  end

  // Next state and next registered outputs.
  always_comb begin
    state_nxt_s          = state_r;
    redirect_valid_nxt_s = 1'b0;
    redirect_pc_nxt_s    = redirect_pc_r;
    flush_if_nxt_s       = 1'b0;
    flush_id_nxt_s       = 1'b0;
    busy_nxt_s           = 1'b0;
    timer_load_s         = 1'b0;
    timer_dec_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (taken_s) begin
          state_nxt_s          = FLUSH;
          redirect_valid_nxt_s = 1'b1;
          redirect_pc_nxt_s    = add_target;
          flush_if_nxt_s       = 1'b1;
          // A JAL proceeds down the pipe, so only EX redirects squash ID/EX.
          flush_id_nxt_s       = (src_s == SRC_EX);
          busy_nxt_s           = 1'b1;
          timer_load_s         = 1'b1;
        end else begin
          state_nxt_s          = IDLE;
        end
      end
      FLUSH: begin
        timer_dec_s = 1'b1;
        if (timer_done_s) begin
          state_nxt_s    = IDLE;
        end else begin
          flush_if_nxt_s = 1'b1;
          busy_nxt_s     = 1'b1;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
      flush_if_r       <= 1'b0;
      flush_id_r       <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      state_r          <= state_nxt_s;
      redirect_valid_r <= redirect_valid_nxt_s;
      redirect_pc_r    <= redirect_pc_nxt_s;
      flush_if_r       <= flush_if_nxt_s;
      flush_id_r       <= flush_id_nxt_s;
      busy_r           <= busy_nxt_s;
    end
  end

  branch_redirect_ctrl_flush_timer #(.W(CNT_W)) u_flush_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .load_val (FLUSH_LOAD),
    .dec      (timer_dec_s),
    .done     (timer_done_s)
  );

  assign ex_gnt         = ex_gnt_s;
  assign id_gnt         = id_gnt_s;
  assign add_pc         = add_pc_s;
  assign add_imm        = add_imm_s;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign flush_if       = flush_if_r;
  assign flush_id       = flush_id_r;
  assign busy           = busy_r;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_taken_r, stat_not_taken_r, stat_jal_r;

  // Grant-edge statistics, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken_r     <= '0;
      stat_not_taken_r <= '0;
      stat_jal_r       <= '0;
    end else begin
      stat_taken_r     <= (ex_gnt_s && ex_taken)  ? sat_inc(stat_taken_r)     : stat_taken_r;
      stat_not_taken_r <= (ex_gnt_s && !ex_taken) ? sat_inc(stat_not_taken_r) : stat_not_taken_r;
      stat_jal_r       <= id_gnt_s                ? sat_inc(stat_jal_r)       : stat_jal_r;
    end
  end

  assign stat_taken     = stat_taken_r;
  assign stat_not_taken = stat_not_taken_r;
  assign stat_jal       = stat_jal_r;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed cases plus random traffic
// against a cycle-level reference model of arbitration, redirect and flush window.
module tb_branch_redirect_ctrl;

  localparam int FLUSH_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_req = 1'b0, ex_taken = 1'b0, id_req = 1'b0;
  logic [7:0]  ex_pc = 8'h00, id_pc = 8'h00;
  logic [63:0] ex_imm = 64'h0, id_imm = 64'h0;
  logic        ex_gnt, id_gnt;
  logic [7:0]  add_pc, add_target, redirect_pc;
  logic [63:0] add_imm, add_sum;
  logic        redirect_valid, flush_if, flush_id, busy;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_taken, stat_not_taken, stat_jal;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       from_ex;
    logic [7:0] pc;
  } redir_t;
  redir_t exp_q[$];

  int         flush_left = 0;
  logic       first_flush = 1'b0;
  logic       first_ex = 1'b0;
  logic [7:0] exp_rpc = 8'h00;
  int         st_t = 0, st_nt = 0, st_j = 0;

  always #5 clk = ~clk;

  // External shared adder.
  assign add_sum    = 64'(add_pc) + (add_imm << 1);
  assign add_target = add_sum[7:0];

  branch_redirect_ctrl #(.PC_W(8), .IMM_W(64), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_req(ex_req), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_taken(ex_taken), .ex_gnt(ex_gnt),
    .id_req(id_req), .id_pc(id_pc), .id_imm(id_imm), .id_gnt(id_gnt),
    .add_pc(add_pc), .add_imm(add_imm), .add_target(add_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id), .busy(busy)
`ifdef BRANCH_STATS_EN
    , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken), .stat_jal(stat_jal)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] target(input logic [7:0] pc, input logic [63:0] imm);
    logic [63:0] s;
    s = 64'(pc) + imm * 64'd2;
    return s[7:0];
  endfunction

  // One pipeline cycle: drive, check against the model, then advance the model.
  task automatic cycle(input logic e_req, input logic [7:0] e_pc, input logic [63:0] e_imm,
                       input logic e_tk, input logic i_req, input logic [7:0] i_pc,
                       input logic [63:0] i_imm);
    logic idle, eg, ig, taken;
    logic [7:0] tgt;
    @(negedge clk);
    ex_req = e_req; ex_pc = e_pc; ex_imm = e_imm; ex_taken = e_tk;
    id_req = i_req; id_pc = i_pc; id_imm = i_imm;
    #1;
    idle = (flush_left == 0);
    eg = idle && e_req;
    ig = idle && !e_req && i_req;
    check("ex_gnt", ex_gnt, eg);
    check("id_gnt", id_gnt, ig);
    check("flush_if", flush_if, flush_left > 0);
    check("busy", busy, flush_left > 0);
    check("redirect_valid", redirect_valid, first_flush);
    check("flush_id", flush_id, first_flush && first_ex);
    check("redirect_pc", redirect_pc, exp_rpc);
    if (eg) begin
      check("add_pc", add_pc, e_pc);
      check("add_imm", add_imm, e_imm);
    end else if (ig) begin
      check("add_pc", add_pc, i_pc);
      check("add_imm", add_imm, i_imm);
    end else if (idle) begin
      check("add_pc_idle", add_pc, 8'h00);
    end
`ifdef BRANCH_STATS_EN
    check("stat_taken", stat_taken, st_t);
    check("stat_not_taken", stat_not_taken, st_nt);
    check("stat_jal", stat_jal, st_j);
`endif
    taken = (eg && e_tk) || ig;
    tgt = eg ? target(e_pc, e_imm) : target(i_pc, i_imm);
    @(posedge clk);
    if (flush_left > 0) flush_left--;
    first_flush = 1'b0;
    if (eg && e_tk) st_t++;
    if (eg && !e_tk) st_nt++;
    if (ig) st_j++;
    if (taken) begin
      exp_q.push_back('{from_ex: eg, pc: tgt});
      flush_left = FLUSH_CYC;
      first_flush = 1'b1;
      first_ex = eg;
      exp_rpc = tgt;
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0);
  endtask

  task automatic model_reset();
    flush_left = 0; first_flush = 1'b0; first_ex = 1'b0; exp_rpc = 8'h00;
    st_t = 0; st_nt = 0; st_j = 0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_redirect_valid"}, redirect_valid, 1'b0);
    check({tag, "_redirect_pc"}, redirect_pc, 8'h00);
    check({tag, "_flush_if"}, flush_if, 1'b0);
    check({tag, "_flush_id"}, flush_id, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // Scoreboard monitor: every redirect pulse must match the oldest expected one.
  always @(posedge clk) begin
    redir_t e;
    #2;
    if (rst_n && redirect_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_redirect: got pc %0h, expected none", redirect_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_redirect_pc", redirect_pc, e.pc);
        check("sb_flush_id", flush_id, e.from_ex);
      end
    end
  end

  initial begin
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Taken EX branch 0x10 + 4*2.
    cycle(1'b1, 8'h10, 64'd4, 1'b1, 1'b0, 8'h00, 64'h0);
    #1 check("tp1_rpc", redirect_pc, 8'h18);
    check("tp1_flush_id", flush_id, 1'b1);
    idle_n(3);
    // Not-taken EX branch with a competing JAL.
    cycle(1'b1, 8'h30, 64'd7, 1'b0, 1'b1, 8'h44, 64'd3);
    #1 check("tp2_busy", busy, 1'b0);
    idle_n(1);
    // Taken EX with simultaneous JAL: JAL dropped.
    cycle(1'b1, 8'h20, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 8'h50, 64'd1);
    #1 check("tp3_rpc", redirect_pc, 8'h1C);
    cycle(1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 8'h50, 64'd1);
    cycle(1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 8'h50, 64'd1);
    idle_n(1);
    // JAL wrapping past the top of the address space.
    cycle(1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 8'hFC, 64'd2);
    #1 check("tp4_rpc", redirect_pc, 8'h00);
    check("tp4_flush_id", flush_id, 1'b0);
    idle_n(3);

    // Reset during the second flush cycle.
    cycle(1'b1, 8'h40, 64'd8, 1'b1, 1'b0, 8'h00, 64'h0);
    idle_n(1);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h60, 64'd1, 1'b1, 1'b0, 8'h00, 64'h0);
    idle_n(2);
    cycle(1'b1, 8'h61, 64'd2, 1'b1, 1'b0, 8'h00, 64'h0);
    idle_n(2);
    cycle(1'b1, 8'h62, 64'd3, 1'b0, 1'b0, 8'h00, 64'h0);
    cycle(1'b1, 8'h63, 64'd4, 1'b1, 1'b0, 8'h00, 64'h0);
    idle_n(2);
    cycle(1'b1, 8'h64, 64'd5, 1'b0, 1'b0, 8'h00, 64'h0);
    cycle(1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 8'h70, 64'd6);
    idle_n(2);
`ifdef BRANCH_STATS_EN
    #1;
    check("tp6_stat_taken", stat_taken, 16'd3);
    check("tp6_stat_not_taken", stat_not_taken, 16'd2);
    check("tp6_stat_jal", stat_jal, 16'd1);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [63:0] ei, ii;
      ei = ($urandom_range(0, 1) == 0) ? {$urandom(), $urandom()} : 64'($signed(8'($urandom())));
      ii = ($urandom_range(0, 1) == 0) ? {$urandom(), $urandom()} : 64'($signed(8'($urandom())));
      cycle(($urandom_range(0, 2) == 0), 8'($urandom()), ei, 1'($urandom()),
            ($urandom_range(0, 2) == 0), 8'($urandom()), ii);
    end
    idle_n(4);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
